// File: rtl/otter_intc_pkg.sv
// Shared types and constants for the OTTER interrupt controller.
package otter_intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVICE
    } intc_state_t;

    localparam int ID_W = 5;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;

    localparam int STAT_IN_SERVICE_BIT = 31;
    localparam int STAT_REQUESTING_BIT = 30;

endpackage

// File: rtl/otter_intc_prio_enc.sv
// Combinational lowest-index-first priority encoder for the interrupt controller.
module otter_intc_prio_enc
    import otter_intc_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/otter_intr_ctrl.sv
// Multi-source edge-triggered interrupt controller for the OTTER CU FSM.
// Define INTC_SYNC_EN to put a 2-flop synchronizer on every IRQ_IN line.
module otter_intr_ctrl
    import otter_intc_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    input  logic               INT_TAKEN,
    input  logic               MRET_EXEC,
    input  logic               CFG_WE,
    input  logic [1:0]         CFG_ADDR,
    input  logic [31:0]        CFG_WDATA,
    output logic [31:0]        CFG_RDATA,
    output logic               INTR,
    output logic [4:0]         INTR_ID
);

    logic [NUM_SRC-1:0] irq_s;
    logic [NUM_SRC-1:0] prev_reg;
    logic [NUM_SRC-1:0] edge_set;
    logic [NUM_SRC-1:0] enable_reg;
    logic [NUM_SRC-1:0] pending_reg, pending_next;
    logic [NUM_SRC-1:0] w1c_mask;
    logic [NUM_SRC-1:0] id_onehot;
    logic [NUM_SRC-1:0] take_mask;
    logic [ID_W-1:0]    id_reg, id_next;
    logic [ID_W-1:0]    enc_id;
    logic               enc_valid;
    logic               take;
    logic               enable_hit;
    intc_state_t        state_reg, state_next;
    logic               unused_wdata;

`ifdef INTC_SYNC_EN
    logic [NUM_SRC-1:0] sync1_reg, sync2_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= IRQ_IN;
            sync2_reg <= sync1_reg;
        end
    end

    assign irq_s = sync2_reg;
`else
    assign irq_s = IRQ_IN;
`endif

    // History cleared in reset so a line held high through reset gives one event.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= irq_s;
        end
    end

    assign take = (state_reg == ST_REQ) && INT_TAKEN;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign edge_set[gi]  = irq_s[gi] & ~prev_reg[gi];
            assign id_onehot[gi] = (id_reg == ID_W'(gi));
            assign take_mask[gi] = take & id_onehot[gi];
        end
    endgenerate

    assign enable_hit = |(enable_reg & id_onehot);
    assign w1c_mask   = (CFG_WE && CFG_ADDR == ADDR_PENDING) ? CFG_WDATA[NUM_SRC-1:0] : '0;

    // New edges are OR'd in after the clears so a coincident set always wins.
    assign pending_next = (pending_reg & ~(w1c_mask | take_mask)) | edge_set;

    always_ff @(posedge CLK) begin
        if (RST) begin
            enable_reg  <= '0;
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
            if (CFG_WE && CFG_ADDR == ADDR_ENABLE) begin
                enable_reg <= CFG_WDATA[NUM_SRC-1:0];
            end
        end
    end

    otter_intc_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .req   (pending_reg & enable_reg),
        .valid (enc_valid),
        .id    (enc_id)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            id_reg    <= '0;
        end else begin
            state_reg <= state_next;
            id_reg    <= id_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        case (state_reg)
            ST_IDLE: begin
                if (enc_valid) begin
                    id_next    = enc_id;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (INT_TAKEN) begin
                    state_next = ST_SERVICE;
                end else if (!enable_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (MRET_EXEC) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign INTR    = (state_reg == ST_REQ);
    assign INTR_ID = id_reg;

    always_comb begin
        CFG_RDATA = '0;
        case (CFG_ADDR)
            ADDR_ENABLE:  CFG_RDATA = 32'(enable_reg);
            ADDR_PENDING: CFG_RDATA = 32'(pending_reg);
            ADDR_STATUS: begin
                CFG_RDATA[STAT_IN_SERVICE_BIT] = (state_reg == ST_SERVICE);
                CFG_RDATA[STAT_REQUESTING_BIT] = (state_reg == ST_REQ);
                CFG_RDATA[ID_W-1:0]            = id_reg;
            end
            default: CFG_RDATA = '0;
        endcase
    end

    assign unused_wdata = &{1'b0, CFG_WDATA};

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Scoreboard bench for otter_intr_ctrl: register reads, INTR levels and INTR rises
// are queued with expected values and checked by a negedge monitor.
module tb_otter_intr_ctrl;

    localparam int NUM_SRC = 8;
`ifdef INTC_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic               CLK = 1'b0;
    logic               RST;
    logic [NUM_SRC-1:0] IRQ_IN;
    logic               INT_TAKEN;
    logic               MRET_EXEC;
    logic               CFG_WE;
    logic [1:0]         CFG_ADDR;
    logic [31:0]        CFG_WDATA;
    logic [31:0]        CFG_RDATA;
    logic               INTR;
    logic [4:0]         INTR_ID;

    otter_intr_ctrl #(
        .NUM_SRC (NUM_SRC)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IRQ_IN    (IRQ_IN),
        .INT_TAKEN (INT_TAKEN),
        .MRET_EXEC (MRET_EXEC),
        .CFG_WE    (CFG_WE),
        .CFG_ADDR  (CFG_ADDR),
        .CFG_WDATA (CFG_WDATA),
        .CFG_RDATA (CFG_RDATA),
        .INTR      (INTR),
        .INTR_ID   (INTR_ID)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic        lvl_exp_q[$];
    string       lvl_name_q[$];
    int          irq_id_q[$];
    int          irq_cyc_q[$];
    logic        intr_d = 1'b0;

    always @(negedge CLK) begin
        if (rd_exp_q.size() > 0) begin
            logic [31:0] e;
            string       n;
            e = rd_exp_q.pop_front();
            n = rd_name_q.pop_front();
            checks++;
            if (CFG_RDATA !== e) begin
                errors++;
                $display("FAIL %s: CFG_RDATA=%08h expected %08h", n, CFG_RDATA, e);
            end else begin
                $display("ok   %s: CFG_RDATA=%08h", n, CFG_RDATA);
            end
        end
        if (lvl_exp_q.size() > 0) begin
            logic  e;
            string n;
            e = lvl_exp_q.pop_front();
            n = lvl_name_q.pop_front();
            checks++;
            if (INTR !== e) begin
                errors++;
                $display("FAIL %s: INTR=%0b expected %0b", n, INTR, e);
            end else begin
                $display("ok   %s: INTR=%0b", n, INTR);
            end
        end
        if (INTR === 1'b1 && intr_d !== 1'b1) begin
            checks++;
            if (irq_id_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_intr: INTR rose at cycle %0d id %0d, none expected", cyc, INTR_ID);
            end else begin
                int eid;
                int ecyc;
                eid  = irq_id_q.pop_front();
                ecyc = irq_cyc_q.pop_front();
                if (INTR_ID !== 5'(eid) || cyc != ecyc) begin
                    errors++;
                    $display("FAIL intr_rise: id %0d at cycle %0d, expected id %0d at cycle %0d",
                             INTR_ID, cyc, eid, ecyc);
                end else begin
                    $display("ok   intr_rise: id %0d at cycle %0d", INTR_ID, cyc);
                end
            end
        end
        intr_d <= INTR;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
        CFG_WE    = 1'b1;
        CFG_ADDR  = a;
        CFG_WDATA = d;
        step();
        CFG_WE    = 1'b0;
    endtask

    task automatic expect_rd(input logic [1:0] a, input logic [31:0] e, input string n);
        CFG_ADDR = a;
        rd_exp_q.push_back(e);
        rd_name_q.push_back(n);
        step();
    endtask

    task automatic expect_intr(input logic e, input string n);
        lvl_exp_q.push_back(e);
        lvl_name_q.push_back(n);
        step();
    endtask

    task automatic expect_rise(input int id, input int at_cyc);
        irq_id_q.push_back(id);
        irq_cyc_q.push_back(at_cyc);
    endtask

    task automatic wait_intr(input logic v, input int maxc, input string n);
        for (int i = 0; i < maxc; i++) begin
            if (INTR === v) return;
            step();
        end
        checks++;
        errors++;
        $display("FAIL %s: INTR=%0b, expected %0b within %0d cycles", n, INTR, v, maxc);
    endtask

    task automatic pulse_take();
        INT_TAKEN = 1'b1;
        step();
        INT_TAKEN = 1'b0;
    endtask

    task automatic pulse_mret();
        MRET_EXEC = 1'b1;
        step();
        MRET_EXEC = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; IRQ_IN = '0; INT_TAKEN = 1'b0; MRET_EXEC = 1'b0;
        CFG_WE = 1'b0; CFG_ADDR = '0; CFG_WDATA = '0;
        repeat (3) step();
        RST = 1'b0;

        // Reset state
        expect_intr(1'b0, "rst_intr");
        expect_rd(2'd0, 32'h0, "rst_enable");
        expect_rd(2'd1, 32'h0, "rst_pending");
        expect_rd(2'd2, 32'h0, "rst_status");

        // 1: single source, basic handshake
        cfg_wr(2'd0, 32'h05);
        IRQ_IN[2] = 1'b1;
        expect_rise(2, cyc + 2 + SL);
        step();
        IRQ_IN = '0;
        wait_intr(1'b1, 20, "t1_wait");
        expect_rd(2'd2, 32'h4000_0002, "t1_status_req");
        expect_rd(2'd1, 32'h04, "t1_pending");
        pulse_take();
        expect_intr(1'b0, "t1_taken_intr");
        expect_rd(2'd1, 32'h0, "t1_pending_clr");
        expect_rd(2'd2, 32'h8000_0002, "t1_status_svc");
        pulse_mret();
        expect_rd(2'd2, 32'h0000_0002, "t1_status_idle");

        // 2: simultaneous edges, lowest index first, second after mret
        cfg_wr(2'd0, 32'hFF);
        IRQ_IN = 8'h22;
        expect_rise(1, cyc + 2 + SL);
        step();
        IRQ_IN = '0;
        wait_intr(1'b1, 20, "t2_wait1");
        expect_rd(2'd1, 32'h22, "t2_pending_both");
        pulse_take();
        expect_rd(2'd1, 32'h20, "t2_pending_5");
        expect_rise(5, cyc + 2);
        pulse_mret();
        wait_intr(1'b1, 20, "t2_wait2");
        expect_rd(2'd2, 32'h4000_0005, "t2_status_id5");
        pulse_take();
        pulse_mret();
        expect_rd(2'd2, 32'h0000_0005, "t2_status_idle");

        // 3: CU holds off, then software disables the requesting source
        IRQ_IN = 8'h08;
        expect_rise(3, cyc + 2 + SL);
        step();
        IRQ_IN = '0;
        wait_intr(1'b1, 20, "t3_wait");
        for (int i = 0; i < 10; i++) expect_intr(1'b1, "t3_hold");
        cfg_wr(2'd0, 32'hF7);
        step();
        expect_intr(1'b0, "t3_disabled");
        expect_rd(2'd1, 32'h08, "t3_pending_kept");
        expect_rd(2'd2, 32'h0000_0003, "t3_status_idle");
        cfg_wr(2'd1, 32'h08);
        expect_rd(2'd1, 32'h0, "t3_w1c");

        // 4: set wins over INT_TAKEN clear and over W1C
        cfg_wr(2'd0, 32'h10);
        IRQ_IN = 8'h10;
        expect_rise(4, cyc + 2 + SL);
        step();
        IRQ_IN = '0;
        wait_intr(1'b1, 20, "t4_wait");
        IRQ_IN = 8'h10;
        repeat (SL) step();
        pulse_take();
        IRQ_IN = '0;
        expect_rd(2'd2, 32'h8000_0004, "t4_status_svc");
        expect_rd(2'd1, 32'h10, "t4_take_vs_edge");
        cfg_wr(2'd1, 32'h10);
        expect_rd(2'd1, 32'h0, "t4_w1c_alone");
        repeat (3) step();
        IRQ_IN = 8'h10;
        repeat (SL) step();
        cfg_wr(2'd1, 32'h10);
        IRQ_IN = '0;
        expect_rd(2'd1, 32'h10, "t4_w1c_vs_edge");
        cfg_wr(2'd1, 32'h10);

        // 5: reset during SERVICE, line held high through reset
        IRQ_IN = 8'h40;
        RST = 1'b1;
        step();
        expect_intr(1'b0, "t5_rst_intr");
        expect_rd(2'd2, 32'h0, "t5_rst_status");
        expect_rd(2'd0, 32'h0, "t5_rst_enable");
        expect_rd(2'd1, 32'h0, "t5_rst_pending");
        RST = 1'b0;
        repeat (6) step();
        expect_rd(2'd1, 32'h40, "t5_one_event");
        cfg_wr(2'd1, 32'h40);
        repeat (4) step();
        expect_rd(2'd1, 32'h0, "t5_no_second_event");
        IRQ_IN = '0;

        // Ignored handshakes and unmapped register
        INT_TAKEN = 1'b1; MRET_EXEC = 1'b1;
        step();
        INT_TAKEN = 1'b0; MRET_EXEC = 1'b0;
        expect_rd(2'd2, 32'h0, "idle_handshake_ignored");
        cfg_wr(2'd3, 32'hFFFF_FFFF);
        expect_rd(2'd3, 32'h0, "addr3_reads_zero");
        expect_rd(2'd0, 32'h0, "addr3_no_alias");

        repeat (2) step();
        checks++;
        if (irq_id_q.size() != 0) begin
            errors++;
            $display("FAIL missing_intr: %0d expected INTR rises never seen, required 0", irq_id_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
